lwc_sca_rdi_buffer: RTL and testbench

//  Parametrised randomness buffer between the top-level rdi port and the masked datapath.

---
 rtl/lwc_sca_rdi_buffer_if.sv | 23 ++
 rtl/lwc_sca_rdi_buffer.sv | 113 +++++++++++
 tb/tb_lwc_sca_rdi_buffer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lwc_sca_rdi_buffer_if.sv
// Handshake bundle between the rdi randomness port, the buffer and the masked datapath.
// slave: the buffer itself. master: the surrounding producer/consumer.
interface lwc_sca_rdi_buffer_if #(
  parameter int RW_IN = 32,
  parameter int RATIO = 4
);
  logic [RW_IN-1:0]       rdi_data;
  logic                   rdi_valid;
  logic                   rdi_ready;
  logic [RW_IN*RATIO-1:0] rnd_data;
  logic                   rnd_valid;
  logic                   rnd_ready;

  modport slave (
    input  rdi_data, rdi_valid, rnd_ready,
    output rdi_ready, rnd_data, rnd_valid
  );

  modport master (
    output rdi_data, rdi_valid, rnd_ready,
    input  rdi_ready, rnd_data, rnd_valid
  );
endinterface

// File: rtl/lwc_sca_rdi_buffer.sv
// Randomness buffer: packs RATIO rdi words into one wide word, queues up to DEPTH
// wide words (first-word fall-through) and hands each one out exactly once.
// Consumer requests that find the queue empty are flagged and counted.
module lwc_sca_rdi_buffer #(
  parameter int RW_IN           = 32,
  parameter int RATIO           = 4,
  parameter int DEPTH           = 4,
  parameter int ZERO_ON_CONSUME = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  lwc_sca_rdi_buffer_if.slave          bus,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   rnd_level,
  output logic                         starve,
  output logic [15:0]                  starve_cnt
);
  localparam int RW_OUT = RW_IN * RATIO;
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int AW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [AW-1:0] ASM_LAST = AW'(RATIO - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [RW_OUT-1:0] mem [DEPTH];
  logic [RW_OUT-1:0] part_q;
  logic [RW_OUT-1:0] asm_word;
  logic [AW-1:0]     asm_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [LW-1:0]     level_q;
  logic              starve_q;
  logic [15:0]       starve_cnt_q;

  logic asm_last;
  logic full;
  logic empty;
  logic rdy;
  logic accept;
  logic push;
  logic pop;
  logic starve_ev;

  assign asm_last  = (asm_cnt == ASM_LAST);
  assign full      = (level_q == LVL_FULL);
  assign empty     = (level_q == '0);
  // Registered state only: a pop in the same cycle cannot reopen a stalled group.
  assign rdy       = !rst && !flush && (!asm_last || !full);
  assign accept    = bus.rdi_valid && rdy;
  assign push      = accept && asm_last;
  assign pop       = bus.rnd_ready && !empty && !flush && !rst;
  assign starve_ev = bus.rnd_ready && empty;

  // Partial word with the current rdi word merged into its slot (first word in LSBs).
  always_comb begin
    asm_word = part_q;
    asm_word[int'(asm_cnt)*RW_IN +: RW_IN] = bus.rdi_data;
  end

  // Assembly, storage, pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      part_q  <= '0;
      asm_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        if (ZERO_ON_CONSUME != 0) mem[rd_ptr] <= '0;
      end
      if (accept) begin
        if (asm_last) begin
          mem[wr_ptr] <= asm_word;
          wr_ptr      <= wr_ptr + PW'(1);
          part_q      <= '0;
          asm_cnt     <= '0;
        end else begin
          part_q  <= asm_word;
          asm_cnt <= asm_cnt + AW'(1);
        end
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Starvation flag and saturating counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q     <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      starve_q <= starve_ev;
      if (starve_ev && (starve_cnt_q != 16'hFFFF)) starve_cnt_q <= starve_cnt_q + 16'd1;
    end
  end

  // Outputs are forced low while reset is held; stale storage never leaks when invalid.
  always_comb begin
    bus.rdi_ready = rdy;
    bus.rnd_valid = !rst && !empty;
    bus.rnd_data  = bus.rnd_valid ? mem[rd_ptr] : '0;
    rnd_level     = rst ? '0 : level_q;
    starve        = !rst && starve_q;
    starve_cnt    = rst ? '0 : starve_cnt_q;
  end
endmodule

// File: tb/tb_lwc_sca_rdi_buffer.sv
// Directed bench for lwc_sca_rdi_buffer: a 32x4/depth-4 instance tracked by a
// cycle model and scoreboard, plus a 8x1/depth-2 instance driven directly.
module tb_lwc_sca_rdi_buffer;
  logic clk = 1'b0;
  logic rst, flush, rst2, flush2;
  logic [2:0]  lvl;
  logic        st;
  logic [15:0] scnt;
  logic [1:0]  lvl2;
  logic        st2;
  logic [15:0] scnt2;

  lwc_sca_rdi_buffer_if #(.RW_IN(32), .RATIO(4)) b1();
  lwc_sca_rdi_buffer_if #(.RW_IN(8),  .RATIO(1)) b2();

  lwc_sca_rdi_buffer #(.RW_IN(32), .RATIO(4), .DEPTH(4), .ZERO_ON_CONSUME(1)) dut (
    .clk(clk), .rst(rst), .bus(b1), .flush(flush),
    .rnd_level(lvl), .starve(st), .starve_cnt(scnt)
  );

  lwc_sca_rdi_buffer #(.RW_IN(8), .RATIO(1), .DEPTH(2), .ZERO_ON_CONSUME(1)) dut2 (
    .clk(clk), .rst(rst2), .bus(b2), .flush(flush2),
    .rnd_level(lvl2), .starve(st2), .starve_cnt(scnt2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_pops = 0;

  logic [127:0] sb[$];
  logic [127:0] m_part = '0;
  int           m_cnt = 0;
  logic [15:0]  m_scnt = '0;
  logic         m_st = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the main instance: check against the model mid-cycle, then advance the model.
  task automatic cyc();
    logic exp_rdy;
    logic st_now;
    @(negedge clk);
    if (rst) begin
      chk("rst_rdi_ready", b1.rdi_ready, 0);
      chk("rst_rnd_valid", b1.rnd_valid, 0);
      chk("rst_rnd_data", b1.rnd_data, 0);
      chk("rst_rnd_level", lvl, 0);
      chk("rst_starve", st, 0);
      chk("rst_starve_cnt", scnt, 0);
      sb.delete();
      m_part = '0;
      m_cnt  = 0;
      m_scnt = '0;
      m_st   = 1'b0;
    end else begin
      chk("starve", st, m_st);
      chk("starve_cnt", scnt, m_scnt);
      chk("rnd_level", lvl, sb.size());
      chk("rnd_valid", b1.rnd_valid, sb.size() != 0);
      if (sb.size() == 0) chk("rnd_data_idle", b1.rnd_data, 0);
      exp_rdy = !flush && (m_cnt != 3 || sb.size() != 4);
      chk("rdi_ready", b1.rdi_ready, exp_rdy);
      st_now = b1.rnd_ready && (sb.size() == 0);
      if (flush) begin
        sb.delete();
        m_part = '0;
        m_cnt  = 0;
      end else begin
        if (b1.rnd_ready && sb.size() != 0) begin
          chk("sb_data", b1.rnd_data, sb.pop_front());
          n_pops++;
        end
        if (b1.rdi_valid && exp_rdy) begin
          m_part[m_cnt*32 +: 32] = b1.rdi_data;
          if (m_cnt == 3) begin
            sb.push_back(m_part);
            m_part = '0;
            m_cnt  = 0;
          end else begin
            m_cnt++;
          end
        end
      end
      m_st = st_now;
      if (st_now && m_scnt != 16'hFFFF) m_scnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; rst2 = 1'b1; flush2 = 1'b0;
    b1.rdi_valid = 1'b0; b1.rdi_data = '0; b1.rnd_ready = 1'b0;
    b2.rdi_valid = 1'b0; b2.rdi_data = '0; b2.rnd_ready = 1'b0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 1'b0;
    #1 chk("post_rst_rdi_ready", b1.rdi_ready, 1);

    // T1: four words assemble into one wide word, LSB first
    for (int i = 1; i <= 4; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = 32'(i); cyc();
    end
    b1.rdi_valid = 1'b0; #1;
    chk("t1_valid", b1.rnd_valid, 1);
    chk("t1_data", b1.rnd_data, 128'h00000004_00000003_00000002_00000001);
    chk("t1_level", lvl, 1);
    b1.rnd_ready = 1'b1; cyc(); b1.rnd_ready = 1'b0;

    // T2: fill to DEPTH, stall on the last word of the fifth group, release by one pop
    for (int i = 0; i < 19; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = $urandom; cyc();
    end
    b1.rdi_data = $urandom; #1;
    chk("t2_full_level", lvl, 4);
    chk("t2_stall", b1.rdi_ready, 0);
    cyc();
    chk("t2_stall_hold", b1.rdi_ready, 0);
    b1.rnd_ready = 1'b1; #1;
    chk("t2_stall_during_pop", b1.rdi_ready, 0);
    cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t2_ready_after_pop", b1.rdi_ready, 1);
    cyc();
    b1.rdi_valid = 1'b0; b1.rnd_ready = 1'b1;
    repeat (4) cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t2_drained", lvl, 0);

    // T3: full-rate stream in and out
    n_pops = 0;
    b1.rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = $urandom; cyc();
      chk("t3_level_le1", lvl <= 3'd1, 1);
    end
    b1.rdi_valid = 1'b0; cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t3_pop_count", n_pops, 10);
    chk("t3_empty", lvl, 0);

    // T6a: reset mid-group discards the partial word
    b1.rdi_valid = 1'b1;
    b1.rdi_data = 32'hDEAD0001; cyc();
    b1.rdi_data = 32'hDEAD0002; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    b1.rdi_valid = 1'b0;
    repeat (3) cyc();
    chk("t6_no_stale_valid", b1.rnd_valid, 0);
    for (int i = 1; i <= 4; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = 32'(i * 32'h11); cyc();
    end
    b1.rdi_valid = 1'b0; #1;
    chk("t6_fresh_group", b1.rnd_data, 128'h00000044_00000033_00000022_00000011);
    b1.rnd_ready = 1'b1; cyc(); b1.rnd_ready = 1'b0;

    // T6b: reset while full with a stalled group
    for (int i = 0; i < 19; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = $urandom; cyc();
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    b1.rdi_valid = 1'b0; cyc();
    chk("t6_full_rst_level", lvl, 0);
    chk("t6_full_rst_valid", b1.rnd_valid, 0);
    chk("t6_full_rst_data", b1.rnd_data, 0);

    // T4: starvation pulses, count and saturation
    b1.rnd_ready = 1'b1;
    repeat (3) cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t4_cnt3", scnt, 3);
    chk("t4_starve_hi", st, 1);
    chk("t4_data0", b1.rnd_data, 0);
    cyc();
    chk("t4_starve_lo", st, 0);
    b1.rnd_ready = 1'b1;
    repeat (65531) cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t4_cnt_fffe", scnt, 16'hFFFE);
    b1.rnd_ready = 1'b1;
    repeat (3) cyc();
    b1.rnd_ready = 1'b0; #1;
    chk("t4_cnt_sat", scnt, 16'hFFFF);
    cyc();

    // T5: flush with two stored words, two partial words, concurrent pop and rdi offer
    for (int i = 0; i < 10; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = $urandom; cyc();
    end
    #1 chk("t5_level2", lvl, 2);
    flush = 1'b1; b1.rdi_data = $urandom; b1.rnd_ready = 1'b1; #1;
    chk("t5_flush_rdy", b1.rdi_ready, 0);
    cyc();
    flush = 1'b0; b1.rdi_valid = 1'b0; b1.rnd_ready = 1'b0; #1;
    chk("t5_level0", lvl, 0);
    chk("t5_valid0", b1.rnd_valid, 0);
    chk("t5_data0", b1.rnd_data, 0);
    chk("t5_cnt_kept", scnt, 16'hFFFF);
    for (int i = 0; i < 4; i++) begin
      b1.rdi_valid = 1'b1; b1.rdi_data = 32'hA0 + 32'(i); cyc();
    end
    b1.rdi_valid = 1'b0; #1;
    chk("t5_lsb_group", b1.rnd_data, 128'h000000A3_000000A2_000000A1_000000A0);
    b1.rnd_ready = 1'b1; cyc(); b1.rnd_ready = 1'b0;
    cyc();

    // Variant RATIO=1, DEPTH=2
    #1;
    chk("v_rst_ready", b2.rdi_ready, 0);
    chk("v_rst_valid", b2.rnd_valid, 0);
    chk("v_rst_level", lvl2, 0);
    chk("v_rst_cnt", scnt2, 0);
    rst2 = 1'b0; #1;
    chk("v_ready", b2.rdi_ready, 1);
    b2.rdi_valid = 1'b1; b2.rdi_data = 8'hA5; tick();
    b2.rdi_data = 8'h3C; #1;
    chk("v_first_valid", b2.rnd_valid, 1);
    chk("v_first_data", b2.rnd_data, 8'hA5);
    chk("v_first_level", lvl2, 1);
    tick();
    b2.rdi_valid = 1'b0; #1;
    chk("v_full_level", lvl2, 2);
    chk("v_full_stall", b2.rdi_ready, 0);
    chk("v_head_kept", b2.rnd_data, 8'hA5);
    b2.rnd_ready = 1'b1; tick();
    b2.rnd_ready = 1'b0; #1;
    chk("v_zero_on_consume", dut2.mem[0], 0);
    chk("v_second_data", b2.rnd_data, 8'h3C);
    chk("v_level_after_pop", lvl2, 1);
    chk("v_ready_after_pop", b2.rdi_ready, 1);
    b2.rdi_valid = 1'b1; b2.rdi_data = 8'h5A; tick();
    b2.rdi_valid = 1'b0; rst2 = 1'b1; #1;
    chk("v_rst_full_level", lvl2, 0);
    chk("v_rst_full_data", b2.rnd_data, 0);
    tick();
    rst2 = 1'b0; #1;
    chk("v_post_rst_valid", b2.rnd_valid, 0);
    b2.rnd_ready = 1'b1; tick();
    b2.rnd_ready = 1'b0; #1;
    chk("v_starve", st2, 1);
    chk("v_starve_cnt", scnt2, 1);
    chk("v_still_empty", b2.rnd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
